// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FSM encoding, instruction field positions and PC alignment helpers live here.
package instr_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } stateT;

    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 26;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WORD_SHIFT       = 2;

    // Instruction addresses are word aligned; the low two bits are never kept.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// master = fetch stage, slave = memory.
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC logic: sequential increment or taken-branch target.
// All arithmetic wraps modulo 2^32.
module pc_next
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        aluZero,
    input  logic [31:0] branchOffset,
    output logic [31:0] pcPlus4,
    output logic [31:0] nextPc
);

    logic [31:0] branchTarget;

    always_comb begin
        pcPlus4      = wordAlign(pc + 32'd4);
        branchTarget = pcPlus4 + (branchOffset << WORD_SHIFT);
        nextPc       = (branch && aluZero) ? wordAlign(branchTarget) : pcPlus4;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues a request at pc, holds the returned word for decode,
// then advances to the next sequential or branch address. Reissues on memory timeout.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 alu_zero,
    input  logic [31:0]          branch_offset,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [5:0]           opcode,
    output logic [31:0]          pc_plus4,
    output logic                 fault
);

    localparam int          CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] START_PC  = wordAlign(RESET_PC);

    stateT            state;
    logic [31:0]      pc;
    logic [31:0]      instrReg;
    logic [CNT_W-1:0] waitCnt;
    logic             faultReg;
    logic [31:0]      nextPc;

    pc_next uPcNext (
        .pc           (pc),
        .branch       (branch),
        .aluZero      (alu_zero),
        .branchOffset (branch_offset),
        .pcPlus4      (pc_plus4),
        .nextPc       (nextPc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= START_PC;
            instrReg <= 32'h0;
            waitCnt  <= '0;
            faultReg <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // An ack on the timeout cycle takes priority over the reissue.
                    if (imem.ack) begin
                        instrReg <= imem.rdata;
                        waitCnt  <= '0;
                        state    <= HOLD;
                    end else if (waitCnt == CNT_LAST) begin
                        waitCnt  <= '0;
                        faultReg <= 1'b1;
                    end else begin
                        waitCnt  <= waitCnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Branch inputs matter only on this edge; memory acks here are ignored.
                    if (!stall) begin
                        pc      <= nextPc;
                        waitCnt <= '0;
                        state   <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign imem.req    = (state == FETCH);
    assign imem.addr   = pc;
    assign instr       = instrReg;
    assign instr_valid = (state == HOLD);
    assign opcode      = instrReg[OPCODE_MSB:OPCODE_LSB];
    assign fault       = faultReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table followed by
// hand-written timeout, reset-during-hold and ack-on-timeout sequences.
`timescale 1ns/1ps
module tb_instr_fetch;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        branch;
        logic        aluZero;
        logic [31:0] offset;
        logic        expReq;
        logic        expValid;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPlus4;
        logic        expFault;
    } vecT;

    localparam int NVEC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, aluZero;
    logic [31:0] branchOffset;
    logic [31:0] instr;
    logic        instrValid;
    logic [5:0]  opcode;
    logic [31:0] pcPlus4;
    logic        fault;

    int checks = 0;
    int errors = 0;

    vecT vecs [NVEC];

    instr_fetch_if imemBus ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imemBus),
        .stall         (stall),
        .branch        (branch),
        .alu_zero      (aluZero),
        .branch_offset (branchOffset),
        .instr         (instr),
        .instr_valid   (instrValid),
        .opcode        (opcode),
        .pc_plus4      (pcPlus4),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                         input logic br, input logic az, input logic [31:0] off);
        imemBus.ack   = ack;
        imemBus.rdata = rdata;
        stall         = st;
        branch        = br;
        aluZero       = az;
        branchOffset  = off;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] expInstr;
        // ack rdata stall br az offset | req valid addr instr plus4 fault
        vecs[0]  = '{1'b1, 32'h8C22_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h5,         1'b0, 1'b1, 32'h0000_0000, 32'h8C22_0004, 32'h0000_0004, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h8C22_0004, 32'h0000_0004, 1'b0};
        vecs[3]  = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h8C22_0004, 32'h0000_0004, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h8C22_0004, 32'h0000_0004, 1'b0};
        vecs[5]  = '{1'b1, 32'h1000_0000, 1'b0, 1'b1, 1'b1, 32'h100,       1'b1, 1'b0, 32'h0000_0004, 32'h8C22_0004, 32'h0000_0008, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hE,         1'b0, 1'b1, 32'h0000_0004, 32'h1000_0000, 32'h0000_0008, 1'b0};
        vecs[7]  = '{1'b1, 32'h1000_0007, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 32'h1000_0000, 32'h0000_000C, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hD,         1'b0, 1'b1, 32'h0000_0008, 32'h1000_0007, 32'h0000_000C, 1'b0};
        vecs[9]  = '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h1000_0007, 32'h0000_0044, 1'b0};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0000_0044, 1'b0};
        vecs[11] = '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_003C, 32'h1111_1111, 32'h0000_0040, 1'b0};
        vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0000_003C, 32'h2222_2222, 32'h0000_0040, 1'b0};
        vecs[13] = '{1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h2222_2222, 32'h0000_0044, 1'b0};
        vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0000_0040, 32'h3333_3333, 32'h0000_0044, 1'b0};
        vecs[15] = '{1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0044, 32'h3333_3333, 32'h0000_0048, 1'b0};
        vecs[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFED, 1'b0, 1'b1, 32'h0000_0044, 32'h4444_4444, 32'h0000_0048, 1'b0};
        vecs[17] = '{1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFC, 32'h4444_4444, 32'h0000_0000, 1'b0};
        vecs[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 32'h0000_0000, 1'b0};
        vecs[19] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h5555_5555, 32'h0000_0004, 1'b0};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_req",    {31'd0, imemBus.req}, 32'd1);
        check("reset_valid",  {31'd0, instrValid},  32'd0);
        check("reset_opcode", {26'd0, opcode},      32'd0);
        check("reset_addr",   imemBus.addr,         32'h0);
        check("reset_fault",  {31'd0, fault},       32'd0);

        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            expInstr = vecs[i].expInstr;
            check($sformatf("vec%0d_req", i),    {31'd0, imemBus.req}, {31'd0, vecs[i].expReq});
            check($sformatf("vec%0d_valid", i),  {31'd0, instrValid},  {31'd0, vecs[i].expValid});
            check($sformatf("vec%0d_addr", i),   imemBus.addr,         vecs[i].expAddr);
            check($sformatf("vec%0d_instr", i),  instr,                expInstr);
            check($sformatf("vec%0d_opcode", i), {26'd0, opcode},      {26'd0, expInstr[31:26]});
            check($sformatf("vec%0d_plus4", i),  pcPlus4,              vecs[i].expPlus4);
            check($sformatf("vec%0d_fault", i),  {31'd0, fault},       {31'd0, vecs[i].expFault});
            $display("vec %0d: addr=%h instr=%h valid=%0b", i, imemBus.addr, instr, instrValid);
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].stall, vecs[i].branch, vecs[i].aluZero, vecs[i].offset);
            if (i == 0) rst = 1'b0;
        end

        // Timeout: 15 ack-less cycles set fault and keep requesting the same address.
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            check($sformatf("wait%0d_fault", n), {31'd0, fault},       32'd0);
            check($sformatf("wait%0d_req", n),   {31'd0, imemBus.req}, 32'd1);
        end
        @(negedge clk);
        check("timeout_fault", {31'd0, fault},       32'd1);
        check("timeout_req",   {31'd0, imemBus.req}, 32'd1);
        check("timeout_addr",  imemBus.addr,         32'h0);
        $display("timeout: fault=%0b addr=%h", fault, imemBus.addr);
        @(negedge clk);
        check("reissue_req",   {31'd0, imemBus.req}, 32'd1);
        check("reissue_valid", {31'd0, instrValid},  32'd0);
        drive(1'b1, 32'h8C22_0004, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("late_ack_valid", {31'd0, instrValid}, 32'd1);
        check("late_ack_instr", instr,               32'h8C22_0004);
        check("late_ack_fault", {31'd0, fault},      32'd1);
        $display("late ack: instr=%h fault=%0b", instr, fault);

        // Move to a non-reset address, then reset while stalled in HOLD.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10);
        @(negedge clk);
        check("jump_addr", imemBus.addr, 32'h0000_0044);
        drive(1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("jump_instr", instr, 32'h6666_6666);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("stall_valid", {31'd0, instrValid}, 32'd1);
        check("stall_addr",  imemBus.addr,        32'h0000_0044);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, instrValid},  32'd0);
        check("async_rst_req",   {31'd0, imemBus.req}, 32'd1);
        check("async_rst_addr",  imemBus.addr,         32'h0);
        check("async_rst_fault", {31'd0, fault},       32'd0);
        check("async_rst_instr", instr,                32'h0);
        $display("async reset: valid=%0b addr=%h fault=%0b", instrValid, imemBus.addr, fault);

        // Ack arriving on the timeout cycle wins: capture, no fault.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int n = 1; n <= 14; n++) @(negedge clk);
        check("pre_edge_fault", {31'd0, fault}, 32'd0);
        drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("ack_wins_valid", {31'd0, instrValid}, 32'd1);
        check("ack_wins_instr", instr,               32'h7777_7777);
        check("ack_wins_fault", {31'd0, fault},      32'd0);
        $display("ack on timeout cycle: instr=%h fault=%0b", instr, fault);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
